// File: rtl/timer_irq_service_pkg.sv
// Shared definitions for the timer interrupt service block: timer register map,
// control bits, FSM states and the registered bus-drive bundle.
package timer_irq_service_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CTRL_RUN =
    16'((1 << CTRL_START) | (1 << CTRL_CONT) | (1 << CTRL_ITO));

  typedef enum logic [3:0] {
    INIT_PL, INIT_PH, INIT_CTRL, IDLE, CLR_ST,
    SNAP_WR, SNAP_RL, SNAP_CL, SNAP_CH
  } state_e;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: ADDR_STATUS, wdata: 16'h0000};

endpackage

// File: rtl/timer_irq_service_if.sv
// Register bus between the service FSM (master) and the interval timer (slave).
// Protocol: a transfer happens in every cycle with tmr_chipselect=1; write_n=0 writes
// tmr_writedata, write_n=1 reads, and tmr_readdata is valid the following cycle.
// There is no waitrequest; tmr_irq is a level held until status is written.
interface timer_irq_service_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_readdata, tmr_irq
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_readdata, tmr_irq
  );
endinterface

// File: rtl/timer_irq_service.sv
// Programs an interval timer at start-up, acknowledges its timeouts as ticks and
// reads 32-bit counter snapshots on request.
module timer_irq_service
  import timer_irq_service_pkg::*;
#(
  parameter logic [31:0] PERIOD = 32'd499999,
  parameter int          TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  timer_irq_service_if.master tmr,
  input  logic              snap_req,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              heartbeat,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic              busy,
  output state_e            state_dbg
);

  state_e            state_q, state_d;
  logic              started_q;
  logic              holdoff_q;
  logic              pending_q;
  bus_t              bus_q, bus_d;
  logic              tick_q;
  logic [TICK_W-1:0] count_q;
  logic              heartbeat_q;
  logic              snap_valid_q;
  logic [15:0]       snap_lo_q;
  logic [31:0]       snap_value_q;

  // The first clock after reset only arms the bus registers with the INIT_PL write.
  always_comb begin
    state_d = state_q;
    if (!started_q) begin
      state_d = INIT_PL;
    end else begin
      case (state_q)
        INIT_PL:   state_d = INIT_PH;
        INIT_PH:   state_d = INIT_CTRL;
        INIT_CTRL: state_d = IDLE;
        IDLE: begin
          if (tmr.tmr_irq && !holdoff_q) state_d = CLR_ST;
          else if (pending_q)            state_d = SNAP_WR;
        end
        CLR_ST:    state_d = IDLE;
        SNAP_WR:   state_d = SNAP_RL;
        SNAP_RL:   state_d = SNAP_CL;
        SNAP_CL:   state_d = SNAP_CH;
        SNAP_CH:   state_d = IDLE;
        default:   state_d = INIT_PL;
      endcase
    end
  end

  // Bus drive is decoded from the next state so it is registered yet aligned with state_q.
  always_comb begin
    bus_d = BUS_IDLE;
    case (state_d)
      INIT_PL:   bus_d = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_PERIOD_L, wdata: PERIOD[15:0]};
      INIT_PH:   bus_d = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_PERIOD_H, wdata: PERIOD[31:16]};
      INIT_CTRL: bus_d = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_CONTROL,  wdata: CTRL_RUN};
      CLR_ST:    bus_d = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_STATUS,   wdata: 16'h0000};
      SNAP_WR:   bus_d = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_SNAP_L,   wdata: 16'h0000};
      SNAP_RL:   bus_d = '{cs: 1'b1, write_n: 1'b1, addr: ADDR_SNAP_L,   wdata: 16'h0000};
      SNAP_CL:   bus_d = '{cs: 1'b1, write_n: 1'b1, addr: ADDR_SNAP_H,   wdata: 16'h0000};
      default:   bus_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT_PL;
      started_q    <= 1'b0;
      holdoff_q    <= 1'b0;
      pending_q    <= 1'b0;
      bus_q        <= BUS_IDLE;
      tick_q       <= 1'b0;
      count_q      <= '0;
      heartbeat_q  <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_lo_q    <= '0;
      snap_value_q <= '0;
    end else begin
      state_q      <= state_d;
      started_q    <= 1'b1;
      holdoff_q    <= (state_q == CLR_ST);
      // A request in the same cycle as SNAP_WR entry is kept for a later snapshot.
      pending_q    <= snap_req | (pending_q & (state_d != SNAP_WR));
      bus_q        <= bus_d;
      tick_q       <= (state_d == CLR_ST);
      if (state_d == CLR_ST) begin
        count_q     <= count_q + 1'b1;
        heartbeat_q <= ~heartbeat_q;
      end
      snap_valid_q <= (state_q == SNAP_CH);
      if (state_q == SNAP_CL) snap_lo_q <= tmr.tmr_readdata;
      if (state_q == SNAP_CH) snap_value_q <= {tmr.tmr_readdata, snap_lo_q};
    end
  end

  assign tmr.tmr_address    = bus_q.addr;
  assign tmr.tmr_chipselect = bus_q.cs;
  assign tmr.tmr_write_n    = bus_q.write_n;
  assign tmr.tmr_writedata  = bus_q.wdata;

  assign tick       = tick_q;
  assign tick_count = count_q;
  assign heartbeat  = heartbeat_q;
  assign snap_valid = snap_valid_q;
  assign snap_value = snap_value_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_timer_irq_service.sv
// Bench for timer_irq_service: behavioural timer slave, transaction-level expected
// queues for bus traffic and snapshots, and tick counters derived from timeouts issued.
module tb_timer_irq_service;
  import timer_irq_service_pkg::*;

  localparam int TW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          snap_req = 1'b0;
  logic          tick, heartbeat, snap_valid, busy;
  logic [TW-1:0] tick_count;
  logic [31:0]   snap_value;
  state_e        state_dbg;

  timer_irq_service_if bus();

  timer_irq_service #(.PERIOD(32'd499999), .TICK_W(TW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tmr        (bus),
    .snap_req   (snap_req),
    .tick       (tick),
    .tick_count (tick_count),
    .heartbeat  (heartbeat),
    .snap_valid (snap_valid),
    .snap_value (snap_value),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- timer slave model ----------------
  logic        irq_set  = 1'b0;
  logic        irq_q    = 1'b0;
  logic [15:0] rd_q     = 16'h0;
  logic [31:0] snap_src = 32'h0;
  logic [31:0] snap_reg = 32'h0;

  always @(posedge clk) begin
    if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == ADDR_STATUS) irq_q <= 1'b0;
    else if (irq_set) irq_q <= 1'b1;
    if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == ADDR_SNAP_L) snap_reg <= snap_src;
    if (bus.tmr_chipselect && bus.tmr_write_n) begin
      case (bus.tmr_address)
        ADDR_SNAP_L: rd_q <= snap_reg[15:0];
        ADDR_SNAP_H: rd_q <= snap_reg[31:16];
        default:     rd_q <= 16'h0;
      endcase
    end
  end

  assign bus.tmr_irq      = irq_q;
  assign bus.tmr_readdata = rd_q;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  int          obs_cyc[$];
  logic [31:0] exp_snap[$];
  logic [31:0] snap_obs[$];
  int          lat_obs[$];
  int          cyc = 0;
  int          leave_cyc = 0;
  int          tick_seen = 0;
  logic        busy_prev = 1'b0;
  int          exp_tick_total = 0;
  int          exp_ticks = 0;
  logic [31:0] last_snap = 32'h0;

  // Bus monitor: {is_read, address, write data} per selected cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (bus.tmr_chipselect) begin
          obs_q.push_back({bus.tmr_write_n, bus.tmr_address,
                           bus.tmr_write_n ? 16'h0 : bus.tmr_writedata});
          obs_cyc.push_back(cyc);
        end
        if (tick) tick_seen++;
        if (busy && !busy_prev) leave_cyc = cyc;
        if (snap_valid) begin
          snap_obs.push_back(snap_value);
          lat_obs.push_back(cyc - leave_cyc);
        end
        busy_prev = busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- expectation builders ----------------
  function automatic logic [19:0] wr(input logic [2:0] a, input logic [15:0] d);
    return {1'b0, a, d};
  endfunction

  function automatic logic [19:0] rd(input logic [2:0] a);
    return {1'b1, a, 16'h0};
  endfunction

  task automatic exp_init();
    exp_q.push_back(wr(3'd2, 16'hA11F));
    exp_q.push_back(wr(3'd3, 16'h0007));
    exp_q.push_back(wr(3'd1, 16'h0007));
  endtask

  task automatic exp_clr();
    exp_q.push_back(wr(3'd0, 16'h0000));
    exp_ticks++;
    exp_tick_total++;
  endtask

  task automatic exp_snap_seq(input logic [31:0] v);
    exp_q.push_back(wr(3'd4, 16'h0000));
    exp_q.push_back(rd(3'd4));
    exp_q.push_back(rd(3'd5));
    exp_snap.push_back(v);
    last_snap = v;
  endtask

  // ---------------- comparison tasks ----------------
  task automatic check_bus(input string tag);
    logic [19:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 20'hFFFFF;
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        void'(obs_cyc.pop_front());
      end
      check_eq({tag, "_bus"}, 32'(o), 32'(e));
    end
    check_eq({tag, "_bus_extra"}, 32'(obs_q.size()), 32'd0);
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic check_init(input string tag);
    int g1, g2;
    g1 = (obs_cyc.size() >= 3) ? obs_cyc[1] - obs_cyc[0] : 0;
    g2 = (obs_cyc.size() >= 3) ? obs_cyc[2] - obs_cyc[1] : 0;
    check_eq({tag, "_gap1"}, 32'(g1), 32'd1);
    check_eq({tag, "_gap2"}, 32'(g2), 32'd1);
    check_bus(tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_snaps(input string tag);
    logic [31:0] e, v;
    int l;
    while (exp_snap.size() > 0) begin
      e = exp_snap.pop_front();
      v = 32'hDEAD_BEEF;
      l = -1;
      if (snap_obs.size() > 0) begin
        v = snap_obs.pop_front();
        l = lat_obs.pop_front();
      end
      check_eq({tag, "_snap_val"}, v, e);
      check_eq({tag, "_snap_lat"}, 32'(l), 32'd4);
    end
    check_eq({tag, "_snap_extra"}, 32'(snap_obs.size()), 32'd0);
    snap_obs.delete();
    lat_obs.delete();
  endtask

  task automatic check_state(input string tag);
    check_bus(tag);
    check_snaps(tag);
    check_eq({tag, "_ticks"}, 32'(tick_seen), 32'(exp_tick_total));
    check_eq({tag, "_count"}, 32'(tick_count), 32'(exp_ticks % (1 << TW)));
    check_eq({tag, "_hb"}, 32'(heartbeat), 32'(exp_ticks % 2));
    check_eq({tag, "_irq_clear"}, 32'(irq_q), 32'd0);
    check_eq({tag, "_snap_hold"}, snap_value, last_snap);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cs"}, 32'(bus.tmr_chipselect), 32'd0);
    check_eq({tag, "_wn"}, 32'(bus.tmr_write_n), 32'd1);
    check_eq({tag, "_addr"}, 32'(bus.tmr_address), 32'd0);
    check_eq({tag, "_wdata"}, 32'(bus.tmr_writedata), 32'd0);
    check_eq({tag, "_tick"}, 32'(tick), 32'd0);
    check_eq({tag, "_count"}, 32'(tick_count), 32'd0);
    check_eq({tag, "_hb"}, 32'(heartbeat), 32'd0);
    check_eq({tag, "_svalid"}, 32'(snap_valid), 32'd0);
    check_eq({tag, "_svalue"}, snap_value, 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic raise_irq();
    irq_set = 1'b1;
    @(negedge clk);
    irq_set = 1'b0;
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_busy_seen"}, 32'(busy), 32'd1);
  endtask

  task automatic settle();
    int quiet;
    quiet = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 100 && quiet < 6; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
    end
    check_eq("settle_quiet", 32'(quiet), 32'd6);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int op, k;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    exp_init();
    settle();
    check_init("init");

    raise_irq();
    exp_clr();
    settle();
    check_state("irq_single");

    snap_src = 32'h0001_2345;
    pulse_snap();
    exp_snap_seq(snap_src);
    settle();
    check_state("snap_fixed");

    snap_src = $urandom;
    raise_irq();
    pulse_snap();
    exp_clr();
    exp_snap_seq(snap_src);
    settle();
    check_state("irq_and_snap");

    snap_src = $urandom;
    pulse_snap();
    wait_busy("merge");
    repeat (3) pulse_snap();
    exp_snap_seq(snap_src);
    exp_snap_seq(snap_src);
    settle();
    check_state("merge");

    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      op = $urandom_range(0, 3);
      snap_src = $urandom;
      case (op)
        0: begin
          raise_irq();
          exp_clr();
        end
        1: begin
          pulse_snap();
          exp_snap_seq(snap_src);
        end
        2: begin
          raise_irq();
          pulse_snap();
          exp_clr();
          exp_snap_seq(snap_src);
        end
        default: begin
          pulse_snap();
          wait_busy("rand_mid");
          raise_irq();
          exp_snap_seq(snap_src);
          exp_clr();
        end
      endcase
      settle();
      check_state($sformatf("rand%0d_op%0d", it, op));
    end

    for (int it = 0; it < 17; it++) begin
      raise_irq();
      exp_clr();
      settle();
      check_state($sformatf("wrap%0d", it));
    end

    snap_src = $urandom;
    pulse_snap();
    k = 0;
    while (state_dbg != SNAP_CL && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("abort_reach_snap_cl", 32'(state_dbg == SNAP_CL), 32'd1);
    #1 reset_n = 1'b0;
    exp_q.push_back(wr(3'd4, 16'h0000));
    exp_q.push_back(rd(3'd4));
    exp_q.push_back(rd(3'd5));
    repeat (3) @(negedge clk);
    check_reset_vals("abort_reset");
    check_bus("abort");
    exp_ticks = 0;
    last_snap = 32'h0;
    reset_n = 1'b1;
    exp_init();
    settle();
    check_init("reinit");
    check_state("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
